// File: rtl/word_fifo32_pkg.sv
// word_fifo32_pkg: default sizes and the pointer-width helper shared by buffer stages
package word_fifo32_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 4;
  function automatic int ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/word_fifo32_if.sv
// word_fifo32_if: valid/ready upstream and downstream handshakes plus occupancy
interface word_fifo32_if
  import word_fifo32_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int AW = ptr_w(DEPTH);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [AW:0]      count;
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/word_fifo32_ptr.sv
// fifo_ptr: wrapping AW-bit pointer with synchronous active-low reset and increment enable
module fifo_ptr #(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inc,
  output logic [AW-1:0] o_ptr
);
  logic [AW-1:0] r_ptr;
  always_ff @(posedge clk)
    if (!rst_n) r_ptr <= '0;
    else if (i_inc) r_ptr <= r_ptr + 1'b1;
  assign o_ptr = r_ptr;
endmodule

// File: rtl/word_fifo32.sv
// word_fifo32: first-word-fall-through FIFO buffering inv32 words for a stalling sink
module word_fifo32
  import word_fifo32_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic          clk,
  input logic          rst_n,
  word_fifo32_if.slave bus
);
  localparam int AW = ptr_w(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_count;
  logic [AW-1:0]    w_wr_ptr, w_rd_ptr;
  logic             w_push, w_pop;
  assign bus.in_ready  = rst_n & (r_count != FULL);
  assign bus.out_valid = rst_n & (r_count != '0);
  assign bus.out_data  = r_mem[w_rd_ptr];
  assign bus.count     = r_count;
  assign w_push = bus.in_valid & bus.in_ready;
  assign w_pop  = bus.out_valid & bus.out_ready;
  fifo_ptr #(.AW(AW)) u_wr (.clk(clk), .rst_n(rst_n), .i_inc(w_push), .o_ptr(w_wr_ptr));
  fifo_ptr #(.AW(AW)) u_rd (.clk(clk), .rst_n(rst_n), .i_inc(w_pop),  .o_ptr(w_rd_ptr));
  always_ff @(posedge clk)
    if (!rst_n) for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    else if (w_push) r_mem[w_wr_ptr] <= bus.in_data;
  // count is kept as its own up/down counter so full/empty never depend on pointer compares
  always_ff @(posedge clk)
    if (!rst_n) r_count <= '0;
    else if (w_push & ~w_pop) r_count <= r_count + 1'b1;
    else if (~w_push & w_pop) r_count <= r_count - 1'b1;
endmodule
